// File: rtl/forno_sequenciador.sv
// Microwave oven sequencer: BCD keypad time entry, per-second countdown,
// pause/resume on stop or open door, and a one-cycle completion beep.
module forno_sequenciador #(
    parameter int unsigned TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       mag_on,
    output logic       timer_done,
    output logic       beep,
    output logic [1:0] state
);
    localparam int unsigned   PW        = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        cur_state, nxt_state;
    logic [3:0]    mt_q, mu_q, st_q, su_q;
    logic [3:0]    mt_d, mu_d, st_d, su_d;
    logic [3:0]    dec_mt, dec_mu, dec_st, dec_su;
    logic [PW-1:0] presc_q, presc_d;
    logic          beep_q, beep_d;
    logic          start_hist, stop_hist, clear_hist;
    logic          start_evt, stop_evt, clear_evt;
    logic          time_zero, dec_zero, key_ok;

    assign start_evt = start_hist & ~startn;
    assign stop_evt  = stop_hist  & ~stopn;
    assign clear_evt = clear_hist & ~clearn;

    assign time_zero = ({mt_q, mu_q, st_q, su_q} == '0);
    assign key_ok    = key_valid && (key_digit <= 4'd9);

    // One-second BCD decrement; sec_tens wraps to 5 so loaded 6..9 still count down.
    always_comb begin
        dec_mt = mt_q;
        dec_mu = mu_q;
        dec_st = st_q;
        dec_su = su_q - 4'd1;
        if (su_q == 4'd0) begin
            dec_su = 4'd9;
            if (st_q == 4'd0) begin
                dec_st = 4'd5;
                if (mu_q == 4'd0) begin
                    dec_mu = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end else begin
                    dec_mu = mu_q - 4'd1;
                end
            end else begin
                dec_st = st_q - 4'd1;
            end
        end
    end

    assign dec_zero = ({dec_mt, dec_mu, dec_st, dec_su} == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state  <= IDLE;
            mt_q       <= '0;
            mu_q       <= '0;
            st_q       <= '0;
            su_q       <= '0;
            presc_q    <= '0;
            beep_q     <= 1'b0;
            start_hist <= 1'b1;
            stop_hist  <= 1'b1;
            clear_hist <= 1'b1;
        end else begin
            cur_state  <= nxt_state;
            mt_q       <= mt_d;
            mu_q       <= mu_d;
            st_q       <= st_d;
            su_q       <= su_d;
            presc_q    <= presc_d;
            beep_q     <= beep_d;
            start_hist <= startn;
            stop_hist  <= stopn;
            clear_hist <= clearn;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        mt_d      = mt_q;
        mu_d      = mu_q;
        st_d      = st_q;
        su_d      = su_q;
        presc_d   = presc_q;
        beep_d    = 1'b0;
        if (clear_evt) begin
            nxt_state = IDLE;
            mt_d      = '0;
            mu_d      = '0;
            st_d      = '0;
            su_d      = '0;
            presc_d   = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start_evt && !stop_evt && door_closed && !time_zero) begin
                        nxt_state = COOK;
                        presc_d   = '0;
                    end else if (key_ok) begin
                        mt_d = mu_q;
                        mu_d = st_q;
                        st_d = su_q;
                        su_d = key_digit;
                    end
                end
                COOK: begin
                    if (stop_evt || !door_closed) begin
                        nxt_state = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        mt_d    = dec_mt;
                        mu_d    = dec_mu;
                        st_d    = dec_st;
                        su_d    = dec_su;
                        if (dec_zero) begin
                            nxt_state = DONE;
                            beep_d    = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_evt && !stop_evt && door_closed) begin
                        nxt_state = COOK;
                    end
                end
                DONE: begin
                    if (!door_closed) begin
                        nxt_state = IDLE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    assign min_tens   = mt_q;
    assign min_units  = mu_q;
    assign sec_tens   = st_q;
    assign sec_units  = su_q;
    assign mag_on     = (cur_state == COOK) && door_closed;
    assign timer_done = (cur_state == DONE);
    assign beep       = beep_q;
    assign state      = cur_state;

endmodule

// File: tb/tb_forno_sequenciador.sv
// Bench for forno_sequenciador: directed scenarios against fixed values and a
// randomized run against a seconds/minutes arithmetic reference model.
module tb_forno_sequenciador;
    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       clearn = 1'b1;
    logic       door_closed = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       mag_on, timer_done, beep;
    logic [1:0] state;
    logic [15:0] disp;

    int errors = 0;
    int checks = 0;

    // reference model: state code, digits, prescaler, beep, button history
    int m_state;
    int m_d[4];
    int m_presc;
    bit m_beep;
    bit m_ps, m_pp, m_pc;

    forno_sequenciador #(.TICKS_PER_SEC(TPS)) dut (
        .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
        .clearn(clearn), .door_closed(door_closed), .key_valid(key_valid),
        .key_digit(key_digit), .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units), .mag_on(mag_on),
        .timer_done(timer_done), .beep(beep), .state(state)
    );

    assign disp = {min_tens, min_units, sec_tens, sec_units};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_d     = '{0, 0, 0, 0};
        m_presc = 0;
        m_beep  = 0;
        m_ps    = 1;
        m_pp    = 1;
        m_pc    = 1;
    endtask

    task automatic model_step();
        bit st, sp, cl, nb;
        int mins, secs;
        st = m_ps && !startn;
        sp = m_pp && !stopn;
        cl = m_pc && !clearn;
        nb = 0;
        if (cl) begin
            m_state = 0;
            m_d     = '{0, 0, 0, 0};
            m_presc = 0;
        end else if (m_state == 0) begin
            if (st && !sp && door_closed && (m_d[0] + m_d[1] + m_d[2] + m_d[3]) != 0) begin
                m_state = 1;
                m_presc = 0;
            end else if (key_valid && key_digit < 10) begin
                m_d[0] = m_d[1];
                m_d[1] = m_d[2];
                m_d[2] = m_d[3];
                m_d[3] = int'(key_digit);
            end
        end else if (m_state == 1) begin
            if (sp || !door_closed) begin
                m_state = 2;
            end else begin
                m_presc++;
                if (m_presc == TPS) begin
                    m_presc = 0;
                    mins = m_d[0] * 10 + m_d[1];
                    secs = m_d[2] * 10 + m_d[3];
                    if (secs > 0) secs--;
                    else begin
                        mins--;
                        secs = 59;
                    end
                    m_d[0] = mins / 10;
                    m_d[1] = mins % 10;
                    m_d[2] = secs / 10;
                    m_d[3] = secs % 10;
                    if (mins == 0 && secs == 0) begin
                        m_state = 3;
                        nb = 1;
                    end
                end
            end
        end else if (m_state == 2) begin
            if (st && !sp && door_closed) m_state = 1;
        end else begin
            if (!door_closed) m_state = 0;
        end
        m_beep = nb;
        m_ps   = startn;
        m_pp   = stopn;
        m_pc   = clearn;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
    endtask

    task automatic load_time(input logic [15:0] t);
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            key_valid = 1'b1;
            key_digit = t[i*4 +: 4];
            tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic press_start();
        startn = 1'b0;
        tick();
        startn = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_time got=%h want=0000", disp); end
        checks++; if ({mag_on, timer_done, beep} !== 3'b000) begin errors++; $display("FAIL reset_outputs got=%b want=000", {mag_on, timer_done, beep}); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || disp !== 16'h0000) begin errors++; $display("FAIL post_reset got=%0d/%h want=0/0000", state, disp); end
    endtask

    task automatic test_keys();
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd1; tick();
        key_digit = 4'd0; tick();
        key_digit = 4'd5; tick();
        key_valid = 1'b0;
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL keys_105 got=%h want=0105", disp); end
        key_valid = 1'b1;
        key_digit = 4'd12; tick();
        key_valid = 1'b0;
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL key_12_ignored got=%h want=0105", disp); end
        press_start();
        key_valid = 1'b1;
        key_digit = 4'd7; tick();
        key_valid = 1'b0;
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL key_in_cook got=%h want=0105", disp); end
    endtask

    task automatic test_cook_done();
        load_time(16'h0003);
        press_start();
        checks++; if (state !== 2'd1 || mag_on !== 1'b1) begin errors++; $display("FAIL cook_start got=%0d/%b want=1/1", state, mag_on); end
        repeat (11) tick();
        checks++; if (state !== 2'd1 || disp !== 16'h0001) begin errors++; $display("FAIL cook_11 got=%0d/%h want=1/0001", state, disp); end
        tick();
        checks++; if (state !== 2'd3 || timer_done !== 1'b1) begin errors++; $display("FAIL done_state got=%0d/%b want=3/1", state, timer_done); end
        checks++; if (beep !== 1'b1 || mag_on !== 1'b0 || disp !== 16'h0000) begin errors++; $display("FAIL done_outputs got=%b/%b/%h want=1/0/0000", beep, mag_on, disp); end
        tick();
        checks++; if (beep !== 1'b0 || state !== 2'd3) begin errors++; $display("FAIL beep_one_cycle got=%b/%0d want=0/3", beep, state); end
        press_start();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL start_in_done got=%0d want=3", state); end
        door_closed = 1'b0;
        tick();
        door_closed = 1'b1;
        checks++; if (state !== 2'd0 || disp !== 16'h0000) begin errors++; $display("FAIL done_door_idle got=%0d/%h want=0/0000", state, disp); end
    endtask

    task automatic test_borrow();
        logic [15:0] from_t[3] = '{16'h0100, 16'h1000, 16'h0070};
        logic [15:0] to_t[3]   = '{16'h0059, 16'h0959, 16'h0069};
        for (int i = 0; i < 3; i++) begin
            load_time(from_t[i]);
            press_start();
            repeat (3) tick();
            checks++; if (disp !== from_t[i]) begin errors++; $display("FAIL borrow_hold%0d got=%h want=%h", i, disp, from_t[i]); end
            tick();
            checks++; if (disp !== to_t[i]) begin errors++; $display("FAIL borrow_dec%0d got=%h want=%h", i, disp, to_t[i]); end
        end
    endtask

    task automatic test_door_pause();
        load_time(16'h0010);
        press_start();
        repeat (5) tick();
        checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL pause_pre got=%h want=0009", disp); end
        door_closed = 1'b0;
        #1;
        checks++; if (mag_on !== 1'b0) begin errors++; $display("FAIL door_mag_comb got=%b want=0", mag_on); end
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL door_pause got=%0d want=2", state); end
        repeat (8) tick();
        checks++; if (state !== 2'd2 || disp !== 16'h0009) begin errors++; $display("FAIL pause_frozen got=%0d/%h want=2/0009", state, disp); end
        door_closed = 1'b1;
        tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_no_start got=%0d want=2", state); end
        press_start();
        checks++; if (state !== 2'd1 || mag_on !== 1'b1) begin errors++; $display("FAIL resume got=%0d/%b want=1/1", state, mag_on); end
        repeat (2) tick();
        checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL resume_hold got=%h want=0009", disp); end
        tick();
        checks++; if (disp !== 16'h0008) begin errors++; $display("FAIL resume_presc got=%h want=0008", disp); end
    endtask

    task automatic test_priority();
        load_time(16'h0000);
        press_start();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_zero got=%0d want=0", state); end
        load_time(16'h0005);
        door_closed = 1'b0;
        press_start();
        door_closed = 1'b1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_door_open got=%0d want=0", state); end
        tick();
        press_start();
        stopn = 1'b0;
        tick();
        stopn = 1'b1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL stop_pause got=%0d want=2", state); end
        tick();
        startn = 1'b0;
        stopn  = 1'b0;
        tick();
        startn = 1'b1;
        stopn  = 1'b1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL stop_over_start got=%0d want=2", state); end
        tick();
        startn = 1'b0;
        clearn = 1'b0;
        tick();
        startn = 1'b1;
        clearn = 1'b1;
        checks++; if (state !== 2'd0 || disp !== 16'h0000) begin errors++; $display("FAIL clear_over_start got=%0d/%h want=0/0000", state, disp); end
        tick();
    endtask

    task automatic test_reset_cook();
        load_time(16'h0040);
        press_start();
        repeat (3) tick();
        checks++; if (mag_on !== 1'b1 || disp !== 16'h0040) begin errors++; $display("FAIL rst_pre got=%b/%h want=1/0040", mag_on, disp); end
        resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (mag_on !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL rst_async got=%b/%0d want=0/0", mag_on, state); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        checks++; if (state !== 2'd0 || disp !== 16'h0000) begin errors++; $display("FAIL rst_release got=%0d/%h want=0/0000", state, disp); end
    endtask

    task automatic test_random();
        logic [20:0] obs, exp;
        resetn = 1'b0;
        model_reset();
        tick();
        resetn = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            startn      = ($urandom_range(0, 7) != 0);
            stopn       = ($urandom_range(0, 24) != 0);
            clearn      = ($urandom_range(0, 149) != 0);
            door_closed = ($urandom_range(0, 49) != 0);
            key_valid   = ($urandom_range(0, 19) == 0);
            key_digit   = 4'($urandom_range(0, 15));
            tick();
            obs = {state, disp, mag_on, timer_done, beep};
            exp = {2'(m_state), 4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3]),
                   1'(m_state == 1 && door_closed), 1'(m_state == 3), m_beep};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d got=%h want=%h", n, obs, exp);
            end
        end
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1; key_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keys();
        test_cook_done();
        test_borrow();
        test_door_pause();
        test_priority();
        test_reset_cook();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
